// File: rtl/cordic_iter_engine_if.sv
// Request/result handshake bundle for the iterative CORDIC engine.
// The engine attaches to the slave modport; the requester/consumer side uses master.
interface cordic_iter_engine_if #(
   parameter int WIDTH = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    mode;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic signed [31:0]      z_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH+1:0] x_out;
   logic signed [WIDTH+1:0] y_out;
   logic signed [31:0]      z_out;
   logic                    mode_out;

   modport slave (
      input  in_valid, mode, x_in, y_in, z_in, out_ready,
      output in_ready, out_valid, x_out, y_out, z_out, mode_out
   );

   modport master (
      output in_valid, mode, x_in, y_in, z_in, out_ready,
      input  in_ready, out_valid, x_out, y_out, z_out, mode_out
   );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: one shared add/shift datapath stepped ITER times per request.
// Rotation (mode=0) drives z to 0; vectoring (mode=1) drives y to 0. Gain K is not compensated.
//
// state  | meaning
// S_IDLE | waiting for a request, in_ready=1
// S_RUN  | micro-rotations i=0..ITER-1, then one cycle to register the result
// S_DONE | result presented (out_valid=1) until out_ready
module cordic_iter_engine #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   cordic_iter_engine_if.slave  bus
);
   localparam int W = WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                r_state;
   logic signed [W-1:0]   r_x;
   logic signed [W-1:0]   r_y;
   logic [31:0]           r_z;
   logic                  r_mode;
   logic                  r_zero;
   logic [4:0]            r_i;
   logic                  r_out_valid;
   logic signed [W-1:0]   r_x_out;
   logic signed [W-1:0]   r_y_out;
   logic [31:0]           r_z_out;
   logic                  r_mode_out;

   logic                  w_in_ready;
   logic                  w_accept;
   logic signed [W-1:0]   w_xs;
   logic signed [W-1:0]   w_ys;
   logic signed [W-1:0]   w_xl;
   logic signed [W-1:0]   w_yl;
   logic [31:0]           w_zl;
   logic                  w_zero;
   logic                  w_d_pos;
   logic signed [W-1:0]   w_xsh;
   logic signed [W-1:0]   w_ysh;
   logic [31:0]           w_atan;
   logic signed [W-1:0]   w_xn;
   logic signed [W-1:0]   w_yn;
   logic [31:0]           w_zn;

   // round(atan(2^-i) / 2pi * 2^32)
   function automatic logic [31:0] atan_lut(input logic [4:0] i);
      case (i)
         5'd0:    atan_lut = 32'h2000_0000;
         5'd1:    atan_lut = 32'h12E4_051D;
         5'd2:    atan_lut = 32'h09FB_385B;
         5'd3:    atan_lut = 32'h0511_11D4;
         5'd4:    atan_lut = 32'h028B_0D43;
         5'd5:    atan_lut = 32'h0145_D7E1;
         5'd6:    atan_lut = 32'h00A2_F61E;
         5'd7:    atan_lut = 32'h0051_7C55;
         5'd8:    atan_lut = 32'h0028_BE53;
         5'd9:    atan_lut = 32'h0014_5F2F;
         5'd10:   atan_lut = 32'h000A_2F98;
         5'd11:   atan_lut = 32'h0005_17CC;
         5'd12:   atan_lut = 32'h0002_8BE6;
         5'd13:   atan_lut = 32'h0001_45F3;
         5'd14:   atan_lut = 32'h0000_A2FA;
         5'd15:   atan_lut = 32'h0000_517D;
         5'd16:   atan_lut = 32'h0000_28BE;
         5'd17:   atan_lut = 32'h0000_145F;
         5'd18:   atan_lut = 32'h0000_0A30;
         5'd19:   atan_lut = 32'h0000_0518;
         5'd20:   atan_lut = 32'h0000_028C;
         5'd21:   atan_lut = 32'h0000_0146;
         5'd22:   atan_lut = 32'h0000_00A3;
         5'd23:   atan_lut = 32'h0000_0051;
         5'd24:   atan_lut = 32'h0000_0029;
         5'd25:   atan_lut = 32'h0000_0014;
         5'd26:   atan_lut = 32'h0000_000A;
         5'd27:   atan_lut = 32'h0000_0005;
         5'd28:   atan_lut = 32'h0000_0003;
         5'd29:   atan_lut = 32'h0000_0001;
         5'd30:   atan_lut = 32'h0000_0001;
         default: atan_lut = 32'h0000_0000;
      endcase
   endfunction

   assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   assign w_xs   = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
   assign w_ys   = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
   assign w_zero = bus.mode && (bus.x_in == '0) && (bus.y_in == '0);

   // Fold the operand into the +/-90 degree range the micro-rotations can converge over
   always_comb begin
      w_xl = w_xs;
      w_yl = w_ys;
      w_zl = bus.z_in;
      if (bus.mode) begin
         w_zl = 32'h0000_0000;
         if (w_xs[W-1]) begin
            w_xl = -w_xs;
            w_yl = -w_ys;
            w_zl = 32'h8000_0000;
         end
      end else begin
         case (bus.z_in[31:30])
            2'b01: begin
               w_xl = -w_ys;
               w_yl = w_xs;
               w_zl = {2'b00, bus.z_in[29:0]};
            end
            2'b10: begin
               w_xl = w_ys;
               w_yl = -w_xs;
               w_zl = {2'b11, bus.z_in[29:0]};
            end
            default: ;
         endcase
      end
   end

   assign w_d_pos = r_mode ? r_y[W-1] : ~r_z[31];
   assign w_xsh   = r_x >>> r_i;
   assign w_ysh   = r_y >>> r_i;
   assign w_atan  = atan_lut(r_i);
   assign w_xn    = w_d_pos ? (r_x - w_ysh) : (r_x + w_ysh);
   assign w_yn    = w_d_pos ? (r_y + w_xsh) : (r_y - w_xsh);
   assign w_zn    = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_mode      <= 1'b0;
         r_zero      <= 1'b0;
         r_i         <= '0;
         r_out_valid <= 1'b0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_z_out     <= '0;
         r_mode_out  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x     <= w_xl;
                  r_y     <= w_yl;
                  r_z     <= w_zl;
                  r_mode  <= bus.mode;
                  r_zero  <= w_zero;
                  r_i     <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_i == 5'(ITER)) begin
                  r_x_out     <= r_zero ? '0 : r_x;
                  r_y_out     <= r_zero ? '0 : r_y;
                  r_z_out     <= r_zero ? '0 : r_z;
                  r_mode_out  <= r_mode;
                  r_out_valid <= 1'b1;
                  r_i         <= '0;
                  r_state     <= S_DONE;
               end else begin
                  r_x <= w_xn;
                  r_y <= w_yn;
                  r_z <= w_zn;
                  r_i <= r_i + 5'd1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (bus.in_valid) begin
                     r_x     <= w_xl;
                     r_y     <= w_yl;
                     r_z     <= w_zl;
                     r_mode  <= bus.mode;
                     r_zero  <= w_zero;
                     r_i     <= '0;
                     r_state <= S_RUN;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.x_out     = r_x_out;
   assign bus.y_out     = r_y_out;
   assign bus.z_out     = r_z_out;
   assign bus.mode_out  = r_mode_out;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: bit-exact reference model feeding a scoreboard queue,
// a table of known-angle vectors checked against ideal values, and handshake/reset sequences.
module tb_cordic_iter_engine;
   localparam int WIDTH = 16;
   localparam int ITER  = 16;
   localparam int W     = WIDTH + 2;
   localparam longint ZTOL = 64'd262144;

   localparam logic [31:0] ATAN [0:30] = '{
      32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4, 32'h028B0D43, 32'h0145D7E1,
      32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D, 32'h000028BE, 32'h0000145F,
      32'h00000A30, 32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001,
      32'h00000001};

   typedef struct {
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic [31:0]         z;
      logic                m;
   } res_t;

   typedef struct {
      logic        m;
      int          x;
      int          y;
      logic [31:0] z;
      int          ex;
      int          ey;
      logic [31:0] ez;
      int          txy;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   cordic_iter_engine_if #(.WIDTH(WIDTH)) bus();
   cordic_iter_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   res_t sb[$];

   always @(posedge clock) cyc <= cyc + 1;

   function automatic res_t model(input logic m, input logic signed [15:0] xi,
                                  input logic signed [15:0] yi, input logic [31:0] zi);
      logic signed [W-1:0] x, y, t;
      logic [31:0]         z;
      logic                d;
      res_t                r;
      x = {{2{xi[15]}}, xi};
      y = {{2{yi[15]}}, yi};
      z = zi;
      if (m) begin
         z = 32'h0;
         if (x < 0) begin
            x = -x;
            y = -y;
            z = 32'h8000_0000;
         end
      end else if (zi[31:30] == 2'b01) begin
         t = -y; y = x; x = t;
         z = {2'b00, zi[29:0]};
      end else if (zi[31:30] == 2'b10) begin
         t = y; y = -x; x = t;
         z = {2'b11, zi[29:0]};
      end
      for (int i = 0; i < ITER; i++) begin
         d = m ? (y < 0) : (z[31] == 1'b0);
         t = x;
         if (d) begin
            x = x - (y >>> i);
            y = y + (t >>> i);
            z = z - ATAN[i];
         end else begin
            x = x + (y >>> i);
            y = y - (t >>> i);
            z = z + ATAN[i];
         end
      end
      if (m && xi == 0 && yi == 0) begin
         x = '0; y = '0; z = '0;
      end
      r.x = x; r.y = y; r.z = z; r.m = m;
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      n_vec++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic chk_ang(input string name, input logic [31:0] act, input logic [31:0] exp,
                          input longint tol);
      logic [31:0] df;
      longint      d;
      n_vec++;
      df = act - exp;
      d  = longint'($signed(df));
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic send(input logic m, input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic [31:0] z);
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.mode = m; bus.x_in = x; bus.y_in = y; bus.z_in = z;
      while (!bus.in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("accept_wait", longint'(n), 0, 99);
      @(posedge clock);
      #1;
      acc_cyc = cyc;
      bus.in_valid = 1'b0;
      sb.push_back(model(m, x, y, z));
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!bus.out_valid && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk({tag, "_latency"}, longint'(cyc - acc_cyc), ITER + 1, 0);
   endtask

   task automatic recv(input string tag, input bit ideal, input vec_t v);
      res_t e;
      wait_out(tag);
      @(negedge clock);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_x"}, bus.x_out, e.x, 0);
         chk({tag, "_y"}, bus.y_out, e.y, 0);
         chk_ang({tag, "_z"}, bus.z_out, e.z, 0);
         chk({tag, "_mode"}, bus.mode_out, e.m, 0);
         if (ideal) begin
            chk({tag, "_x_ideal"}, bus.x_out, v.ex, v.txy);
            chk({tag, "_y_ideal"}, bus.y_out, v.ey, v.txy);
            chk_ang({tag, "_z_ideal"}, bus.z_out, v.ez, (v.txy == 0) ? 0 : ZTOL);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.out_ready = 1'b0;
   endtask

   vec_t tv[8];
   vec_t none;
   res_t ea;
   int   hi_cnt;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Integer-only datapath: floor-biased shifts leave the vectoring magnitudes a few LSB high
      tv[0] = '{1'b0,   9949,     0, 32'h2000_0000,  11585, 11585, 32'h0000_0000,  4};
      tv[1] = '{1'b0,   9949,     0, 32'h6000_0000, -11585, 11585, 32'h0000_0000,  4};
      tv[2] = '{1'b1,   3000,  4000, 32'h0000_0000,   8234,     0, 32'd633866811,  8};
      tv[3] = '{1'b1,  -3000,     0, 32'h0000_0000,   4940,     0, 32'h8000_0000,  8};
      tv[4] = '{1'b1,      0,     0, 32'h1234_5678,      0,     0, 32'h0000_0000,  0};
      tv[5] = '{1'b1, -32768,     0, 32'h0000_0000,  53961,     0, 32'h8000_0000, 16};
      tv[6] = '{1'b0,      0, -10000, 32'hA000_0000, -11644, 11644, 32'h0000_0000,  8};
      tv[7] = '{1'b0,  12000,  5000, 32'h0000_0000,  19761,  8234, 32'h0000_0000,  8};
      none  = '{1'b0, 0, 0, 32'h0, 0, 0, 32'h0, 0};

      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 1'b0;
      bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;

      // reset with random inputs toggling
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         bus.in_valid = 1'($urandom); bus.out_ready = 1'($urandom); bus.mode = 1'($urandom);
         bus.x_in = 16'($urandom); bus.y_in = 16'($urandom); bus.z_in = $urandom;
         #1;
         chk("rst_in_ready", bus.in_ready, 1, 0);
         chk("rst_out_valid", bus.out_valid, 0, 0);
         chk("rst_outputs", longint'(bus.x_out | bus.y_out) | longint'(bus.z_out) | longint'(bus.mode_out), 0, 0);
      end
      @(negedge clock);
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_in_ready", bus.in_ready, 1, 0);
      chk("idle_out_valid", bus.out_valid, 0, 0);
      chk("idle_outputs", longint'(bus.x_out | bus.y_out) | longint'(bus.z_out), 0, 0);

      for (int k = 0; k < 8; k++) begin
         send(tv[k].m, 16'(tv[k].x), 16'(tv[k].y), tv[k].z);
         recv($sformatf("vec%0d", k), 1'b1, tv[k]);
      end

      for (int k = 0; k < 6; k++) begin
         send(1'($urandom), 16'(int'($urandom_range(0, 40000)) - 20000),
              16'(int'($urandom_range(0, 40000)) - 20000), $urandom);
         recv($sformatf("rnd%0d", k), 1'b0, none);
      end

      // stall with a pending request, then release and accept in the same cycle
      send(1'b0, 16'sd9949, 16'sd0, 32'h2000_0000);
      wait_out("stall_a");
      ea = sb[0];
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         bus.in_valid = 1'b1; bus.mode = 1'($urandom);
         bus.x_in = 16'($urandom); bus.y_in = 16'($urandom); bus.z_in = $urandom;
         #1;
         chk("stall_in_ready", bus.in_ready, 0, 0);
         chk("stall_out_valid", bus.out_valid, 1, 0);
         chk("stall_x_hold", bus.x_out, ea.x, 0);
         chk_ang("stall_z_hold", bus.z_out, ea.z, 0);
      end
      @(negedge clock);
      bus.mode = 1'b1; bus.x_in = 16'sd3000; bus.y_in = 16'sd4000; bus.z_in = 32'h0;
      bus.out_ready = 1'b1;
      #1;
      chk("release_in_ready", bus.in_ready, 1, 0);
      @(posedge clock);
      #1;
      acc_cyc = cyc;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      void'(sb.pop_front());
      sb.push_back(model(1'b1, 16'sd3000, 16'sd4000, 32'h0));
      chk("b2b_out_valid_drop", bus.out_valid, 0, 0);
      chk("b2b_in_ready_run", bus.in_ready, 0, 0);
      recv("b2b", 1'b1, tv[2]);

      // reset in the middle of RUN aborts the request
      send(1'b0, 16'sd12000, 16'sd5000, 32'h1000_0000);
      repeat (5) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0, 0);
      chk("abort_in_ready", bus.in_ready, 1, 0);
      void'(sb.pop_back());
      @(negedge clock);
      reset_n = 1'b1;
      hi_cnt = 0;
      for (int k = 0; k < ITER + 5; k++) begin
         @(negedge clock);
         if (bus.out_valid) hi_cnt++;
      end
      chk("abort_no_result", hi_cnt, 0, 0);
      chk("abort_idle", bus.in_ready, 1, 0);

      send(1'b0, 16'sd9949, 16'sd0, 32'h6000_0000);
      recv("post_abort", 1'b1, tv[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
